// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle MIPS control unit.
//   Instruction, Zero, MemReady : datapath -> control (IR contents, ALU zero flag, memory ready)
//   PCEn..ALUControl            : control  -> datapath enables and mux selects
//   IllegalOp                   : one-cycle pulse on an unsupported opcode/funct
//   StateDbg                    : current FSM state encoding
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int INSTR_W  = 32,
  parameter int ALUCTL_W = 3
);
  logic [INSTR_W-1:0]  Instruction;
  logic                Zero;
  logic                MemReady;
  logic                PCEn;
  logic                IorD;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                IllegalOp;
  logic [3:0]          StateDbg;

  modport master (
    input  Instruction, Zero, MemReady,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp, StateDbg
  );

  modport slave (
    output Instruction, Zero, MemReady,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp, StateDbg
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle MIPS datapath (shared memory, IR, A/B/ALUOut).
// Ports: clk (rising edge), rst (synchronous, active high), bus (master modport of
// multicycle_control_unit_if carrying IR/flags in and datapath enables out).
// Optional feature macro: MCU_MUL_EN builds the MULWAIT state and its cycle counter
// so funct 011100 runs a MUL_CYCLES-long multiply; without it that funct is illegal.
//
// state      | meaning
// FETCH   0  | read instruction at PC, PC+4, wait for MemReady
// DECODE  1  | decode opcode, branch target into ALUOut
// MEMADR  2  | compute load/store address
// MEMRD   3  | memory read, wait for MemReady
// MEMWB   4  | write MDR to rt
// MEMWR   5  | memory write, wait for MemReady
// EXEC    6  | R-type ALU operation
// ALUWB   7  | write ALUOut to rd
// ADDIEX  8  | A + SignImm
// ADDIWB  9  | write ALUOut to rt
// BRANCH 10  | compare A/B, take branch on Zero
// JUMP   11  | load jump target
// MULWAIT 12 | multiply in progress (MCU_MUL_EN only)
module multicycle_control_unit #(
  parameter int INSTR_W    = 32,
  parameter int ALUCTL_W   = 3,
  parameter int MUL_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
`ifdef MCU_MUL_EN
    S_MULWAIT = 4'd12,
`endif
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b100);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b110);

  state_t state;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;
  logic [ALUCTL_W-1:0] funct_alu;

  assign opcode = bus.Instruction[INSTR_W-1 -: 6];
  assign funct  = bus.Instruction[5:0];

  // rs/rt/rd/shamt fields are consumed by the datapath, not by control
  logic unused_instr_fields;
  assign unused_instr_fields = ^bus.Instruction[INSTR_W-7:6];

`ifdef MCU_MUL_EN
  localparam logic [ALUCTL_W-1:0] ALU_MUL = ALUCTL_W'(3'b101);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  logic [CNT_W-1:0] mul_cnt;
  logic             funct_mul;
`else
  logic unused_mul_cycles;
  assign unused_mul_cycles = (MUL_CYCLES != 0);
`endif

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
`ifdef MCU_MUL_EN
    funct_mul = 1'b0;
`endif
    case (funct)
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b101010: funct_alu = ALU_SLT;
`ifdef MCU_MUL_EN
      6'b011100: begin
        funct_alu = ALU_MUL;
        funct_mul = 1'b1;
      end
`endif
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
`ifdef MCU_MUL_EN
      mul_cnt <= '0;
`endif
    end else begin
      case (state)
        S_FETCH:  if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_ADDI:      state <= S_ADDIEX;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.MemReady) state <= S_MEMWB;
        S_MEMWR:  if (bus.MemReady) state <= S_FETCH;
        S_EXEC: begin
`ifdef MCU_MUL_EN
          if (funct_mul && MUL_CYCLES > 1) begin
            state   <= S_MULWAIT;
            mul_cnt <= CNT_W'(MUL_CYCLES - 1);
          end else
`endif
          state <= funct_ok ? S_ALUWB : S_FETCH;
        end
`ifdef MCU_MUL_EN
        // down-counter: remaining MULWAIT cycles including this one
        S_MULWAIT: begin
          if (mul_cnt <= CNT_W'(1)) begin
            state   <= S_ALUWB;
            mul_cnt <= '0;
          end else begin
            mul_cnt <= mul_cnt - CNT_W'(1);
          end
        end
`endif
        S_ADDIEX: state <= S_ADDIWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [ALUCTL_W-1:0] aluctl;

  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluctl   = ALU_ADD;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = bus.MemReady;
        pcen    = bus.MemReady;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = !(opcode inside {OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J});
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluctl  = funct_alu;
        illegal = !funct_ok;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca = 1'b1;
        aluctl  = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = bus.Zero;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
`ifdef MCU_MUL_EN
      S_MULWAIT: begin
        alusrca = 1'b1;
        aluctl  = ALU_MUL;
      end
`endif
      default: ;
    endcase
    // reset overrides the current state so an aborted instruction writes nothing
    if (rst) begin
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign bus.PCEn       = pcen;
  assign bus.IorD       = iord;
  assign bus.MemWrite   = memwrite;
  assign bus.IRWrite    = irwrite;
  assign bus.RegDst     = regdst;
  assign bus.MemtoReg   = memtoreg;
  assign bus.RegWrite   = regwrite;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.PCSrc      = pcsrc;
  assign bus.ALUControl = aluctl;
  assign bus.IllegalOp  = illegal;
  assign bus.StateDbg   = state;
endmodule
